// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path:
// FSM encoding, 8N1 frame constants and the baud divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int calc_div(
        input int clk_freq,
        input int baud,
        input int ovs
    );
        return clk_freq / (baud * ovs);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through read port,
// flush and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign count    = cnt;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizer, oversampling prescaler,
// bit FSM and receive FIFO with framing/overrun flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 40000000,
    parameter int BAUD       = 9600,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    input  logic                          clear_i
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVS);
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVS);

    rx_state_t state;
    rx_state_t next_state;

    logic                 rx_q1;
    logic                 rx_s;
    logic                 rx_prev;
    logic [PW-1:0]        presc;
    logic [TW-1:0]        tick_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift;
    logic                 push_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 tick;
    logic                 mid_tick;
    logic                 bit_tick;
    logic                 fall;
    logic                 shift_en;
    logic                 tick_restart;
    logic                 stop_ok;
    logic                 stop_bad;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign tick     = (state != IDLE) && (presc == PW'(DIV-1));
    assign mid_tick = tick && (tick_cnt == TW'(OVS/2-1));
    assign bit_tick = tick && (tick_cnt == TW'(OVS-1));
    assign fall     = rx_prev && !rx_s;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (fall) next_state = START;
            START:   if (mid_tick) next_state = rx_s ? IDLE : DATA;
            DATA:    if (bit_tick && bit_cnt == 3'(DATA_BITS-1))
                         next_state = STOP;
            STOP:    if (bit_tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shift_en     = 1'b0;
        tick_restart = 1'b0;
        stop_ok      = 1'b0;
        stop_bad     = 1'b0;
        unique case (1'b1)
            (state == START): tick_restart = mid_tick && !rx_s;
            (state == DATA):  shift_en     = bit_tick;
            (state == STOP): begin
                stop_ok  = bit_tick && rx_s;
                stop_bad = bit_tick && !rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_q1       <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            presc       <= '0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_q1   <= rx_i;
            rx_s    <= rx_q1;
            rx_prev <= rx_s;
            if (state == IDLE) begin
                presc    <= '0;
                tick_cnt <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                // Realign so data samples land a full bit after mid-start
                if (tick_restart)  tick_cnt <= '0;
                else if (tick)     tick_cnt <= tick_cnt + 1'b1;
            end
            if (state == START) bit_cnt <= '0;
            if (shift_en) begin
                shift   <= {rx_s, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            push_q      <= stop_ok;
            frame_err_q <= stop_bad;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clear_i)
            overrun_q <= 1'b0;
        else if (push_q && fifo_full && !rx_ready_i)
            overrun_q <= 1'b1;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .flush     (clear_i),
        .push      (push_q),
        .push_data (shift),
        .pop       (rx_ready_i),
        .pop_data  (rx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count_o)
    );

    assign rx_valid_o  = !fifo_empty;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core driven by a serial line model.
// Baud is raised so the divisor is 4 and a bit lasts 64 clocks.
module tb_uart_rx_core;

    localparam int CLK_FREQ = 40000000;
    localparam int BAUD     = 625000;
    localparam int OVS      = 16;
    localparam int DEPTH    = 8;
    localparam int BIT      = OVS * (CLK_FREQ / (BAUD * OVS));
    localparam int FRAME    = 10 * BIT;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [3:0] rx_count_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       clear_i;

    int         checks = 0;
    int         errors = 0;
    int         fe_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVS        (OVS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (wb_rst_i),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .rx_count_o  (rx_count_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clear_i     (clear_i)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err_o) fe_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stop bit lands 35 edges after it is driven; pop_align pops in the push cycle
    task automatic send_frame(input logic [7:0] d,
                              input logic stop_bit,
                              input logic pop_align);
        @(posedge clk); #1 rx_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(posedge clk);
            #1 rx_i = d[i];
        end
        repeat (BIT) @(posedge clk);
        #1 rx_i = stop_bit;
        if (pop_align) begin
            repeat (35) @(posedge clk);
            #1;
            chk("same_cycle_head", rx_data_o, exp_q[0]);
            rx_ready_i = 1'b1;
            void'(exp_q.pop_front());
            exp_q.push_back(d);
            @(posedge clk);
            #1 rx_ready_i = 1'b0;
            repeat (28) @(posedge clk);
        end else begin
            repeat (BIT) @(posedge clk);
        end
        #1 rx_i = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_good(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        send_frame(d, 1'b1, 1'b0);
    endtask

    task automatic drain(input int n);
        chk("sb_count", 32'(rx_count_o), 32'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() > 0) begin
                chk("pop_valid", 32'(rx_valid_o), 32'd1);
                chk("pop_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
                rx_ready_i = 1'b1;
                @(posedge clk);
                #1 rx_ready_i = 1'b0;
            end
        end
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
    endtask

    initial begin
        wb_rst_i   = 1'b1;
        rx_i       = 1'b1;
        rx_ready_i = 1'b0;
        clear_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rx_valid_o), 32'd0);
        chk("rst_data", 32'(rx_data_o), 32'd0);
        chk("rst_count", 32'(rx_count_o), 32'd0);
        chk("rst_ferr", 32'(frame_err_o), 32'd0);
        chk("rst_ovr", 32'(overrun_o), 32'd0);
        wb_rst_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        send_good(8'h55);
        chk("valid_after_55", 32'(rx_valid_o), 32'd1);
        send_good(8'hA3);
        chk("count_two", 32'(rx_count_o), 32'd2);
        drain(2);
        chk("no_ferr_good", 32'(fe_cnt), 32'd0);

        @(posedge clk); #1 rx_i = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
        chk("glitch_count", 32'(rx_count_o), 32'd0);
        chk("glitch_valid", 32'(rx_valid_o), 32'd0);

        send_frame(8'h3C, 1'b0, 1'b0);
        chk("ferr_pulses", 32'(fe_cnt), 32'd1);
        chk("ferr_count", 32'(rx_count_o), 32'd0);
        send_good(8'h81);
        drain(1);

        for (int i = 1; i <= 9; i++) send_good(8'(i));
        chk("ovr_count", 32'(rx_count_o), 32'd8);
        chk("ovr_flag", 32'(overrun_o), 32'd1);
        drain(8);
        chk("ovr_sticky", 32'(overrun_o), 32'd1);
        pulse_clear();
        chk("clr_ovr", 32'(overrun_o), 32'd0);
        chk("clr_count", 32'(rx_count_o), 32'd0);

        send_good(8'h5A);
        send_good(8'h6B);
        chk("pre_flush", 32'(rx_count_o), 32'd2);
        pulse_clear();
        exp_q.delete();
        chk("flush_count", 32'(rx_count_o), 32'd0);
        chk("flush_valid", 32'(rx_valid_o), 32'd0);

        for (int i = 0; i < 8; i++) send_good(8'h11 + 8'(i));
        chk("full_count", 32'(rx_count_o), 32'd8);
        send_frame(8'h19, 1'b1, 1'b1);
        chk("fullpop_count", 32'(rx_count_o), 32'd8);
        chk("fullpop_ovr", 32'(overrun_o), 32'd0);
        drain(8);

        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                repeat (BIT * 3 + BIT / 2) @(posedge clk);
                #1 wb_rst_i = 1'b1;
                repeat (BIT * 3) @(posedge clk);
                #1 wb_rst_i = 1'b0;
            end
        join
        repeat (BIT) @(posedge clk);
        #1;
        chk("rst_mid_count", 32'(rx_count_o), 32'd0);
        chk("rst_mid_valid", 32'(rx_valid_o), 32'd0);
        send_good(8'h0F);
        drain(1);
        chk("ferr_total", 32'(fe_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
